fft32_input_framer: RTL

- Serial-to-parallel sample framer that feeds the 32-point DIF FFT datapath.
- Accepts one complex sample per handshake on a streaming input. Collects 32 samples into a frame.
- Presents the whole frame as flattened real and imaginary buses, directly connectable to the FFT's r0..r31 / i0..i31 inputs.
- Ping-pong double buffering: one frame can fill while the FFT holds the previous one.

---
 rtl/fft32_input_framer_if.sv | 40 ++++
 rtl/fft32_input_framer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fft32_input_framer_if.sv
// ---------------------------------------------------------------------------
// fft32_input_framer_if
// Bundle of signals between a sample producer / FFT consumer and the
// fft32_input_framer block.
//
// Signals:
//   s_valid, s_ready, s_last, s_re, s_im : streaming complex-sample input.
//   m_valid, m_ready, m_re, m_im         : whole-frame output. Lane k is
//                                          m_re[k*DW +: DW] and feeds FFT input rk.
//   m_err                                : one-cycle framing-error pulse.
//
// Modports:
//   master : the environment (sample producer plus FFT consumer).
//   slave  : the framer.
// ---------------------------------------------------------------------------
interface fft32_input_framer_if #(
  parameter int DW  = 2,
  parameter int NPT = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic                 s_last;
  logic signed [DW-1:0] s_re;
  logic signed [DW-1:0] s_im;
  logic                 m_valid;
  logic                 m_ready;
  logic [NPT*DW-1:0]    m_re;
  logic [NPT*DW-1:0]    m_im;
  logic                 m_err;

  modport master (
    output s_valid, s_last, s_re, s_im, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_err
  );

  modport slave (
    input  s_valid, s_last, s_re, s_im, m_ready,
    output s_ready, m_valid, m_re, m_im, m_err
  );
endinterface

// File: rtl/fft32_input_framer.sv
// ---------------------------------------------------------------------------
// fft32_input_framer
// Serial-to-parallel framer in front of the 32-point DIF FFT. It collects 32
// complex samples into one of two ping-pong banks. A full bank is presented as
// flat real/imag buses until the FFT accepts it, and the other bank fills in
// the meantime.
//
// Ports:
//   clk    : system clock, rising edge.
//   rst_n  : asynchronous active-low reset. Clears both banks and all flags.
//   bus    : fft32_input_framer_if.slave
//            s_valid/s_ready/s_last/s_re/s_im : sample stream in.
//            m_valid/m_ready/m_re/m_im        : frame out (lane k -> FFT rk).
//            m_err                            : one-cycle framing-error pulse.
//
// Build option:
//   FFT32_FRAMER_BITREV_EN : when defined, sample n is stored in lane
//                            bitrev5(n), so the frame comes out in bit-reversed
//                            order. When undefined, sample n goes to lane n.
// ---------------------------------------------------------------------------
module fft32_input_framer #(
  parameter int DW  = 2,
  parameter int NPT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft32_input_framer_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  bank_state_t          state_reg  [2];
  bank_state_t          state_next [2];
  logic                 wr_bank_reg, wr_bank_next;
  logic                 rd_bank_reg, rd_bank_next;
  logic [4:0]           wr_idx_reg, wr_idx_next;
  logic                 s_ready_reg, s_ready_next;
  logic                 m_valid_reg, m_valid_next;
  logic                 m_err_reg, m_err_next;

  logic signed [DW-1:0] re_mem [2][NPT];
  logic signed [DW-1:0] im_mem [2][NPT];

  logic                 accept;
  logic                 consume;
  logic                 last_idx;
  logic                 early_last;
  logic                 write_en;
  logic [4:0]           wr_lane;

  // Lane in which the current sample is stored.
`ifdef FFT32_FRAMER_BITREV_EN
  assign wr_lane = {wr_idx_reg[0], wr_idx_reg[1], wr_idx_reg[2], wr_idx_reg[3], wr_idx_reg[4]};
`else
  assign wr_lane = wr_idx_reg;
`endif

  assign accept     = bus.s_valid & s_ready_reg;
  assign consume    = m_valid_reg & bus.m_ready;
  assign last_idx   = (wr_idx_reg == 5'd31);
  // An s_last before index 31 drops the partial frame. The s_last sample is
  // not stored.
  assign early_last = accept & bus.s_last & ~last_idx;
  assign write_en   = accept & ~early_last;

  // Next-state logic for both bank FSMs and the shared pointers.
  always_comb begin
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    wr_idx_next  = wr_idx_reg;
    m_err_next   = 1'b0;

    for (int b = 0; b < 2; b++) begin
      state_next[b] = state_reg[b];
      // The read bank is FULL and the write bank is not, so these two updates
      // never target the same bank in one cycle.
      if (consume && (rd_bank_reg == 1'(b))) begin
        state_next[b] = EMPTY;
      end
      if (accept && (wr_bank_reg == 1'(b))) begin
        if (early_last) begin
          state_next[b] = EMPTY;
        end else if (last_idx) begin
          state_next[b] = FULL;
        end else begin
          state_next[b] = FILLING;
        end
      end
    end

    if (consume) begin
      rd_bank_next = ~rd_bank_reg;
    end

    if (accept) begin
      if (early_last) begin
        wr_idx_next = 5'd0;
        m_err_next  = 1'b1;
      end else if (last_idx) begin
        wr_idx_next  = 5'd0;
        wr_bank_next = ~wr_bank_reg;
        m_err_next   = ~bus.s_last;
      end else begin
        wr_idx_next = wr_idx_reg + 5'd1;
      end
    end

    // s_ready looks at the post-edge state. This closes the input in the same
    // cycle in which both banks become FULL, so a held frame is never overwritten.
    s_ready_next = (state_next[wr_bank_next] != FULL);

    // m_valid looks at the pre-edge bank state. A frame completed at edge N
    // appears after edge N+1. A bank that is already FULL can follow a consumed
    // frame back-to-back, with no gap.
    if (consume) begin
      m_valid_next = (state_reg[~rd_bank_reg] == FULL);
    end else begin
      m_valid_next = (state_reg[rd_bank_reg] == FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg[0] <= EMPTY;
      state_reg[1] <= EMPTY;
      wr_bank_reg  <= 1'b0;
      rd_bank_reg  <= 1'b0;
      wr_idx_reg   <= 5'd0;
      s_ready_reg  <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_err_reg    <= 1'b0;
    end else begin
      state_reg[0] <= state_next[0];
      state_reg[1] <= state_next[1];
      wr_bank_reg  <= wr_bank_next;
      rd_bank_reg  <= rd_bank_next;
      wr_idx_reg   <= wr_idx_next;
      s_ready_reg  <= s_ready_next;
      m_valid_reg  <= m_valid_next;
      m_err_reg    <= m_err_next;
    end
  end

  // Bank storage. Every lane drives the output in parallel, so the banks are
  // built from flops and are cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NPT; k++) begin
          re_mem[b][k] <= '0;
          im_mem[b][k] <= '0;
        end
      end
    end else if (write_en) begin
      re_mem[wr_bank_reg][wr_lane] <= bus.s_re;
      im_mem[wr_bank_reg][wr_lane] <= bus.s_im;
    end
  end

  assign bus.s_ready = s_ready_reg;
  assign bus.m_valid = m_valid_reg;
  assign bus.m_err   = m_err_reg;

  // Output lanes come from the read bank. rd_bank only changes on a handshake,
  // so the data stays stable while m_valid is high.
  for (genvar gi = 0; gi < NPT; gi++) begin : g_lane
    assign bus.m_re[gi*DW +: DW] = re_mem[rd_bank_reg][gi];
    assign bus.m_im[gi*DW +: DW] = im_mem[rd_bank_reg][gi];
  end

endmodule
